// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared constants for the instruction/data memory port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_I  = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd10_000_000;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : CPU instruction/data ports and memory bridge bus of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              m_write_enable;
    logic              m_read_enable;
    logic [DATA_W-1:0] m_address;
    logic [DATA_W-1:0] m_writeData;
    logic [DATA_W-1:0] m_readData;
    logic              m_done;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_readData, m_done,
        output i_rdata, i_done, d_rdata, d_done,
               m_write_enable, m_read_enable, m_address, m_writeData
    );

    // CPU core plus bridge side
    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_readData, m_done,
        input  i_rdata, i_done, d_rdata, d_done,
               m_write_enable, m_read_enable, m_address, m_writeData
    );

endinterface

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin picker; the side that did not
//            win last time takes a tie.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2
    import mem_arb_pkg::*;
(
    input  wire logic req_i,
    input  wire logic req_d,
    input  wire logic last_grant,
    output logic      gnt_i,
    output logic      gnt_d
);

    always_comb begin
        gnt_i = req_i && (!req_d || (last_grant == GRANT_D));
        gnt_d = req_d && (!req_i || (last_grant == GRANT_I));
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory bridge between instruction and data ports,
//            one transaction at a time, with a bus-hang watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(TIMEOUT_CYCLES_DEFAULT)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus,
    output logic               hang,
    output logic               proto_err
);

    logic [1:0]           r_state;
    logic                 r_last_grant;
    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic [TIMEOUT_W-1:0] w_wd_cnt_next;
    logic                 r_hang;
    logic                 r_proto_err;

    logic                 r_i_done;
    logic                 r_d_done;
    logic [DATA_W-1:0]    r_i_rdata;
    logic [DATA_W-1:0]    r_d_rdata;
    logic                 r_m_write_enable;
    logic                 r_m_read_enable;
    logic [DATA_W-1:0]    r_m_address;
    logic [DATA_W-1:0]    r_m_writeData;

    logic                 w_d_req;
    logic                 w_gnt_i;
    logic                 w_gnt_d;

    assign w_d_req = bus.d_read | bus.d_write;

    rr_pick2 u_pick (
        .req_i      (bus.i_req),
        .req_d      (w_d_req),
        .last_grant (r_last_grant),
        .gnt_i      (w_gnt_i),
        .gnt_d      (w_gnt_d)
    );

    assign w_wd_cnt_next = (&r_wd_cnt) ? r_wd_cnt : r_wd_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= GRANT_D;
            r_wd_cnt         <= '0;
            r_hang           <= 1'b0;
            r_proto_err      <= 1'b0;
            r_i_done         <= 1'b0;
            r_d_done         <= 1'b0;
            r_i_rdata        <= '0;
            r_d_rdata        <= '0;
            r_m_write_enable <= 1'b0;
            r_m_read_enable  <= 1'b0;
            r_m_address      <= '0;
            r_m_writeData    <= '0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_i) begin
                        r_m_read_enable <= 1'b1;
                        r_m_address     <= bus.i_addr;
                        r_last_grant    <= GRANT_I;
                        r_wd_cnt        <= '0;
                        r_state         <= ST_BUSY_I;
                    end else if (w_gnt_d) begin
                        // A write wins over a simultaneous read; the overlap is flagged.
                        if (bus.d_write) begin
                            r_m_write_enable <= 1'b1;
                            r_m_writeData    <= bus.d_wdata;
                        end else begin
                            r_m_read_enable  <= 1'b1;
                        end
                        if (bus.d_read && bus.d_write) begin
                            r_proto_err <= 1'b1;
                        end
                        r_m_address  <= bus.d_addr;
                        r_last_grant <= GRANT_D;
                        r_wd_cnt     <= '0;
                        r_state      <= ST_BUSY_D;
                    end
                end

                ST_BUSY_I, ST_BUSY_D: begin
                    r_wd_cnt <= w_wd_cnt_next;
                    if ((TIMEOUT_CYCLES != '0) && (w_wd_cnt_next == TIMEOUT_CYCLES)) begin
                        r_hang <= 1'b1;
                    end
                    if (bus.m_done) begin
                        r_m_write_enable <= 1'b0;
                        r_m_read_enable  <= 1'b0;
                        if (r_state == ST_BUSY_I) begin
                            r_i_done <= 1'b1;
                            if (r_m_read_enable) r_i_rdata <= bus.m_readData;
                        end else begin
                            r_d_done <= 1'b1;
                            if (r_m_read_enable) r_d_rdata <= bus.m_readData;
                        end
                        r_state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i_done         = r_i_done;
    assign bus.d_done         = r_d_done;
    assign bus.i_rdata        = r_i_rdata;
    assign bus.d_rdata        = r_d_rdata;
    assign bus.m_write_enable = r_m_write_enable;
    assign bus.m_read_enable  = r_m_read_enable;
    assign bus.m_address      = r_m_address;
    assign bus.m_writeData    = r_m_writeData;
    assign hang               = r_hang;
    assign proto_err          = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a bridge model and
//            a round-robin grant/data reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic hang;
    logic proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .hang      (hang),
        .proto_err (proto_err)
    );

    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model state
    logic        m_last;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
    logic        exp_proto;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tie goes to whichever port did not win last.
    function automatic logic model_pick_d(input logic ri, input logic rd);
        if (ri && rd) return (m_last == GRANT_I);
        return rd;
    endfunction

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_ren"},   32'(bus.m_read_enable),  0);
        chk({tag, "_wen"},   32'(bus.m_write_enable), 0);
        chk({tag, "_dones"}, 32'({bus.i_done, bus.d_done}), 0);
        chk({tag, "_irdata"}, bus.i_rdata, 0);
        chk({tag, "_drdata"}, bus.d_rdata, 0);
        chk({tag, "_addr"},   bus.m_address, 0);
        chk({tag, "_flags"},  32'({hang, proto_err}), 0);
        tick();
        tick();
        reset = 1'b1;
        m_last     = GRANT_D;
        exp_irdata = '0;
        exp_drdata = '0;
        exp_proto  = 1'b0;
        tick();
    endtask

    // Starts in an IDLE cycle with requests already driven; ends in the
    // following IDLE cycle.
    task automatic do_txn(input string tag, input int lat, input bit drop);
        logic        win_d, is_wr;
        logic [31:0] ea, ewd, rd;
        win_d = model_pick_d(bus.i_req, bus.d_read | bus.d_write);
        is_wr = win_d && bus.d_write;
        ea    = win_d ? bus.d_addr : bus.i_addr;
        ewd   = bus.d_wdata;
        if (win_d && bus.d_read && bus.d_write) exp_proto = 1'b1;

        tick();
        chk({tag, "_ren"},  32'(bus.m_read_enable),  32'(!is_wr));
        chk({tag, "_wen"},  32'(bus.m_write_enable), 32'(is_wr));
        chk({tag, "_addr"}, bus.m_address, ea);
        if (is_wr) chk({tag, "_wdata"}, bus.m_writeData, ewd);
        m_last = win_d ? GRANT_D : GRANT_I;

        repeat (lat) tick();
        chk({tag, "_hold_en"}, 32'({bus.m_write_enable, bus.m_read_enable}), 32'({is_wr, !is_wr}));
        chk({tag, "_hold_done"}, 32'({bus.i_done, bus.d_done}), 0);

        rd             = $urandom;
        bus.m_readData = rd;
        bus.m_done     = 1'b1;
        tick();
        bus.m_done     = 1'b0;
        bus.m_readData = $urandom;
        if (!is_wr) begin
            if (win_d) exp_drdata = rd;
            else       exp_irdata = rd;
        end
        chk({tag, "_en_off"}, 32'({bus.m_write_enable, bus.m_read_enable}), 0);
        chk({tag, "_i_done"}, 32'(bus.i_done), 32'(!win_d));
        chk({tag, "_d_done"}, 32'(bus.d_done), 32'(win_d));
        chk({tag, "_i_rdata"}, bus.i_rdata, exp_irdata);
        chk({tag, "_d_rdata"}, bus.d_rdata, exp_drdata);
        chk({tag, "_proto"}, 32'(proto_err), 32'(exp_proto));

        if (drop) begin
            if (win_d) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else begin
                bus.i_req = 1'b0;
            end
        end
        tick();
        chk({tag, "_pulse_end"}, 32'({bus.i_done, bus.d_done}), 0);
        chk({tag, "_idle_en"}, 32'({bus.m_write_enable, bus.m_read_enable}), 0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.m_readData = '0;
        bus.m_done     = 1'b0;
        tick();
        do_reset("rst0");

        // Instruction fetch alone, bridge answers 20 cycles after the grant
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0040;
        do_txn("ionly", 19, 1'b1);
        chk("ionly_value", bus.i_rdata, exp_irdata);
        chk("ionly_hang_noabort", 32'(hang), 1);

        // Data write leaves both read registers alone
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_1000;
        bus.d_wdata = 32'hCAFE_F00D;
        do_txn("dwr", 5, 1'b1);

        // Stray m_done while idle produces nothing
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        chk("idle_mdone", 32'({bus.i_done, bus.d_done, bus.m_read_enable, bus.m_write_enable}), 0);
        tick();
        chk("idle_mdone2", 32'({bus.i_done, bus.d_done}), 0);

        // Simultaneous requests after reset: I first, then D back-to-back
        do_reset("rst1");
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_2000;
        do_txn("tie_i", 3, 1'b1);
        do_txn("tie_d", 3, 1'b1);

        // Both held: grants alternate
        bus.i_req  = 1'b1;
        bus.d_read = 1'b1;
        for (int k = 0; k < 4; k++) do_txn("alt", 2, 1'b0);
        bus.i_req  = 1'b0;
        bus.d_read = 1'b0;
        tick();

        // Read and write together: write performed, sticky protocol flag
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_3000;
        bus.d_wdata = 32'h1234_5678;
        do_txn("proto", 4, 1'b1);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0200;
        do_txn("proto_sticky", 2, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 24; k++) begin
            bus.i_req   = 1'($urandom_range(0, 1));
            bus.d_read  = 1'($urandom_range(0, 1));
            bus.d_write = 1'($urandom_range(0, 3) == 0);
            if (!(bus.i_req || bus.d_read || bus.d_write)) bus.i_req = 1'b1;
            bus.i_addr  = $urandom;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            do_txn("rnd", $urandom_range(1, 8), 1'b1);
        end
        bus.i_req   = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        tick();
        chk("rnd_nohang", 32'(hang), 0);

        // Reset in the middle of a data read aborts it
        do_reset("rst2");
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_4000;
        tick();
        chk("midrst_grant", 32'(bus.m_read_enable), 1);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("midrst_en", 32'({bus.m_write_enable, bus.m_read_enable}), 0);
        chk("midrst_done", 32'({bus.i_done, bus.d_done}), 0);
        tick();
        bus.d_read = 1'b0;
        tick();
        reset = 1'b1;
        m_last = GRANT_D;
        exp_irdata = '0;
        exp_drdata = '0;
        exp_proto  = 1'b0;
        tick();
        chk("midrst_after", 32'({bus.d_done, bus.m_read_enable, bus.m_write_enable}), 0);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0300;
        bus.d_read = 1'b1;
        do_txn("midrst_tie", 2, 1'b1);
        bus.i_req  = 1'b0;
        bus.d_read = 1'b0;
        tick();

        // Watchdog: bridge never answers
        do_reset("rst3");
        bus.i_req = 1'b1;
        tick();
        repeat (11) tick();
        chk("wd_early", 32'(hang), 0);
        repeat (9) tick();
        chk("wd_set", 32'(hang), 1);
        chk("wd_ren", 32'(bus.m_read_enable), 1);
        repeat (5) tick();
        chk("wd_sticky", 32'(hang), 1);
        bus.i_req = 1'b0;
        do_reset("rst4");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
